// File: rtl/counter_bus_reader.sv
// counter_bus_reader: samples the shared count bus, checks count continuity and buffers samples in a FIFO
module counter_bus_reader #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PERIOD     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        sample_req,
    input  logic                        resync,
    output logic                        bus_en,
    input  logic [WIDTH-1:0]            bus_q,
    output logic [WIDTH-1:0]            data_out,
    output logic                        data_valid,
    input  logic                        data_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        seq_err,
    output logic                        overflow,
    input  logic                        err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(PERIOD);

    typedef enum logic [1:0] {IDLE, ENABLE, SAMPLE, RELEASE} state_t;

    state_t           state_q, state_d;
    logic             bus_en_q, bus_en_d;
    logic             running_q, running_d;
    logic [PW-1:0]    tick_cnt_q, tick_cnt_d;
    logic             pending_q, pending_d;
    logic             first_q, first_d;
    logic             resync_seen_q, resync_seen_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] delta_q, delta_d;
    logic             seq_err_q, seq_err_d;
    logic             overflow_q, overflow_d;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic             tick, trig, capture, pop, full, push, mismatch;

    always_comb begin
        tick     = running_q && tick_cnt_q == PW'(PERIOD - 1);
        trig     = sample_req || tick;
        capture  = state_q == SAMPLE;
        pop      = level_q != '0 && data_ready;
        full     = level_q == LW'(FIFO_DEPTH);
        push     = capture && (!full || pop);
        mismatch = capture && !(first_q || resync_seen_q || resync) && bus_q != last_q + delta_q;
        case (state_q)
            IDLE:    state_d = (trig || pending_q) ? ENABLE : IDLE;
            ENABLE:  state_d = SAMPLE;
            SAMPLE:  state_d = RELEASE;
            default: state_d = IDLE;
        endcase
        // a trigger outside IDLE is remembered once and consumed by the next IDLE cycle
        pending_d     = state_q == IDLE ? 1'b0 : pending_q || trig;
        bus_en_d      = state_d == ENABLE || state_d == SAMPLE;
        running_d     = stop ? 1'b0 : start ? 1'b1 : running_q;
        tick_cnt_d    = (stop || start || !running_q || tick) ? '0 : tick_cnt_q + PW'(1);
        delta_d       = capture ? WIDTH'(1) : delta_q + WIDTH'(1);
        resync_seen_d = capture ? 1'b0 : resync_seen_q || resync;
        first_d       = capture ? 1'b0 : first_q;
        last_d        = capture ? bus_q : last_q;
        seq_err_d     = mismatch || (seq_err_q && !err_clr);
        overflow_d    = (capture && full && !pop) || (overflow_q && !err_clr);
        mem_d         = mem_q;
        if (push)
            mem_d[wr_q] = bus_q;
        wr_d          = wr_q + AW'(push);
        rd_d          = rd_q + AW'(pop);
        level_d       = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            bus_en_q      <= 1'b0;
            running_q     <= 1'b0;
            tick_cnt_q    <= '0;
            pending_q     <= 1'b0;
            first_q       <= 1'b1;
            resync_seen_q <= 1'b0;
            last_q        <= '0;
            delta_q       <= '0;
            seq_err_q     <= 1'b0;
            overflow_q    <= 1'b0;
            wr_q          <= '0;
            rd_q          <= '0;
            level_q       <= '0;
            mem_q         <= '{default: '0};
        end else begin
            state_q       <= state_d;
            bus_en_q      <= bus_en_d;
            running_q     <= running_d;
            tick_cnt_q    <= tick_cnt_d;
            pending_q     <= pending_d;
            first_q       <= first_d;
            resync_seen_q <= resync_seen_d;
            last_q        <= last_d;
            delta_q       <= delta_d;
            seq_err_q     <= seq_err_d;
            overflow_q    <= overflow_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            level_q       <= level_d;
            mem_q         <= mem_d;
        end
    end

    assign bus_en     = bus_en_q;
    assign data_out   = mem_q[rd_q];
    assign data_valid = level_q != '0;
    assign fifo_level = level_q;
    assign seq_err    = seq_err_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_counter_bus_reader.sv
// tb_counter_bus_reader: free-running counter model on the bus, FIFO scoreboard and directed sequences
module tb_counter_bus_reader;
    logic       clk = 1'b0;
    logic       rst, start, stop, sample_req, resync, data_ready, err_clr, ld;
    logic [7:0] ld_val, cnt, bus_q, data_out, v;
    logic       bus_en, data_valid, seq_err, overflow;
    logic [2:0] fifo_level;
    int         n_chk = 0, n_fail = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        bit ld;
        bit rs;
        bit rs_cap;
        bit clr_cap;
        bit exp_err;
    } vec_t;
    vec_t tbl [7];

    counter_bus_reader #(.WIDTH(8), .FIFO_DEPTH(4), .PERIOD(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_req(sample_req),
        .resync(resync), .bus_en(bus_en), .bus_q(bus_q), .data_out(data_out),
        .data_valid(data_valid), .data_ready(data_ready), .fifo_level(fifo_level),
        .seq_err(seq_err), .overflow(overflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) cnt <= 8'd0;
        else     cnt <= ld ? ld_val : cnt + 8'd1;

    assign bus_q = bus_en ? cnt : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req_pulse(output logic [7:0] val);
        val = cnt + 8'd2;
        sample_req = 1'b1;
        step(1);
        sample_req = 1'b0;
    endtask

    always @(negedge clk)
        if (!rst && data_valid && data_ready) begin
            chk("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                chk("sb_data_out", data_out, exp_q.pop_front());
        end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, 1, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 0, 1};
        tbl[2] = '{0, 0, 0, 0, 0};
        tbl[3] = '{1, 0, 0, 1, 1};
        tbl[4] = '{0, 1, 0, 0, 0};
        tbl[5] = '{1, 0, 1, 0, 0};
        tbl[6] = '{0, 0, 0, 1, 0};
        rst = 1; start = 0; stop = 0; sample_req = 0; resync = 0;
        data_ready = 0; err_clr = 0; ld = 0; ld_val = 8'h40;
        step(3);
        chk("rst_bus_en", bus_en, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_data_out", data_out, 0);
        rst = 0;
        // one-shot request in cycle 10
        step(10);
        req_pulse(v);
        chk("t1_bus_en_11", bus_en, 1);
        step(1);
        chk("t1_bus_en_12", bus_en, 1);
        chk("t1_valid_12", data_valid, 0);
        step(1);
        chk("t1_bus_en_13", bus_en, 0);
        chk("t1_valid_13", data_valid, 1);
        chk("t1_data_13", data_out, 8'h0C);
        chk("t1_level_13", fifo_level, 1);
        chk("t1_seq_err", seq_err, 0);
        step(1);
        chk("t1_hold_data", data_out, 8'h0C);
        chk("t1_hold_valid", data_valid, 1);
        exp_q.push_back(8'h0C);
        data_ready = 1;
        step(1);
        chk("t1_drained", data_valid, 0);
        // periodic sampling across the 0xF8 -> 0x08 wrap
        for (int i = 0; i < 300 && cnt != 8'd230; i++) step(1);
        start = 1;
        step(1);
        start = 0;
        exp_q.push_back(8'hF8);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h18);
        step(51);
        stop = 1;
        step(1);
        stop = 0;
        step(20);
        chk("t2_sb_empty", exp_q.size(), 0);
        chk("t2_seq_err", seq_err, 0);
        chk("t2_valid", data_valid, 0);
        // load / resync / err_clr table
        for (int i = 0; i < 7; i++) begin
            ld = tbl[i].ld;
            resync = tbl[i].rs;
            step(1);
            ld = 0;
            resync = 0;
            step(2);
            req_pulse(v);
            exp_q.push_back(v);
            step(1);
            resync = tbl[i].rs_cap;
            err_clr = tbl[i].clr_cap;
            step(1);
            resync = 0;
            err_clr = 0;
            chk($sformatf("t3_row%0d_seq_err", i), seq_err, tbl[i].exp_err);
            err_clr = 1;
            step(1);
            err_clr = 0;
            chk($sformatf("t3_row%0d_cleared", i), seq_err, 0);
        end
        // five captures into a four-deep FIFO with no consumer
        data_ready = 0;
        for (int i = 0; i < 5; i++) begin
            req_pulse(v);
            if (i < 4) exp_q.push_back(v);
            step(3);
        end
        chk("t4_level", fifo_level, 4);
        chk("t4_overflow", overflow, 1);
        chk("t4_valid", data_valid, 1);
        chk("t4_seq_err", seq_err, 0);
        data_ready = 1;
        step(6);
        chk("t4_level_drained", fifo_level, 0);
        err_clr = 1;
        step(1);
        err_clr = 0;
        chk("t4_ovf_cleared", overflow, 0);
        // full FIFO with a pop on the capture edge keeps the sample
        data_ready = 0;
        for (int i = 0; i < 5; i++) begin
            req_pulse(v);
            exp_q.push_back(v);
            if (i == 4) begin
                step(1);
                data_ready = 1;
                step(1);
                chk("t4b_level", fifo_level, 4);
                chk("t4b_overflow", overflow, 0);
                step(1);
            end else
                step(3);
        end
        step(6);
        chk("t4b_level_drained", fifo_level, 0);
        // request in SAMPLE and tick in RELEASE collapse into one extra transaction
        start = 1;
        step(1);
        start = 0;
        step(12);
        req_pulse(v);
        exp_q.push_back(v);
        step(1);
        sample_req = 1;
        step(1);
        sample_req = 0;
        chk("t5_release_bus_en", bus_en, 0);
        step(1);
        chk("t5_idle_bus_en", bus_en, 0);
        step(1);
        chk("t5_extra_bus_en", bus_en, 1);
        exp_q.push_back(v + 8'd4);
        stop = 1;
        step(1);
        stop = 0;
        step(25);
        chk("t5_sb_empty", exp_q.size(), 0);
        chk("t5_level", fifo_level, 0);
        chk("t5_bus_en", bus_en, 0);
        chk("t5_seq_err", seq_err, 0);
        // asynchronous reset in SAMPLE with data held and overflow set
        data_ready = 0;
        for (int i = 0; i < 5; i++) begin
            req_pulse(v);
            step(3);
        end
        chk("t6_pre_overflow", overflow, 1);
        req_pulse(v);
        step(1);
        chk("t6_pre_bus_en", bus_en, 1);
        rst = 1;
        #1;
        chk("t6_bus_en", bus_en, 0);
        chk("t6_valid", data_valid, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_seq_err", seq_err, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_data_out", data_out, 0);
        step(1);
        rst = 0;
        step(2);
        chk("t6_post_bus_en", bus_en, 0);
        chk("final_sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
